// File: rtl/instr_fetch_unit.sv
// Instruction fetch front end: PC sequencing, one-outstanding memory reads, prefetch FIFO to decode.
// Define FETCH_BYPASS_EN to forward a returning word straight to decode when the FIFO is empty.
module instr_fetch_unit #(
  parameter int                    DATA_WIDTH = 32,
  parameter int                    ADDR_WIDTH = 32,
  parameter int                    FIFO_DEPTH = 4,
  parameter logic [ADDR_WIDTH-1:0] RESET_PC   = '0
) (
  input  logic                  i_clk,
  input  logic                  i_rst,
  output logic                  o_mem_req,
  output logic [ADDR_WIDTH-1:0] o_mem_addr,
  input  logic                  i_mem_ready,
  input  logic                  i_mem_rvalid,
  input  logic [DATA_WIDTH-1:0] i_mem_rdata,
  output logic                  o_instr_valid,
  output logic [DATA_WIDTH-1:0] o_instr,
  output logic [ADDR_WIDTH-1:0] o_instr_pc,
  input  logic                  i_instr_ready,
  input  logic                  i_redirect,
  input  logic [ADDR_WIDTH-1:0] i_redirect_pc
);

  localparam int PTR_W = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam logic [PTR_W:0] DEPTH_CNT = (PTR_W+1)'(FIFO_DEPTH);

  localparam logic [1:0] S_REQ     = 2'd0;
  localparam logic [1:0] S_WAIT    = 2'd1;
  localparam logic [1:0] S_DISCARD = 2'd2;

  logic [1:0]            state, state_nxt;
  logic [ADDR_WIDTH-1:0] fetch_pc;
  logic [ADDR_WIDTH-1:0] req_pc;
  logic [ADDR_WIDTH-1:0] redirect_target;

  logic [DATA_WIDTH-1:0] fifo_data [FIFO_DEPTH];
  logic [ADDR_WIDTH-1:0] fifo_pc   [FIFO_DEPTH];
  logic [PTR_W-1:0]      rd_ptr, wr_ptr;
  logic [PTR_W:0]        count;

  logic fifo_empty, fifo_full;
  logic accept, wait_resp, bypass, push, pop;

  assign fifo_empty      = (count == '0);
  assign fifo_full       = (count == DEPTH_CNT);
  assign redirect_target = i_redirect_pc & ~ADDR_WIDTH'(3);

  assign o_mem_req  = !i_rst && (state == S_REQ) && !fifo_full;
  assign o_mem_addr = fetch_pc;
  assign accept     = o_mem_req && i_mem_ready;

  // A live response (not stale, not cancelled by a same-cycle redirect).
  assign wait_resp = (state == S_WAIT) && i_mem_rvalid && !i_redirect;

`ifdef FETCH_BYPASS_EN
  assign bypass = wait_resp && fifo_empty;
`else
  assign bypass = 1'b0;
`endif

  assign o_instr_valid = !i_rst && (!fifo_empty || bypass);
  assign pop           = o_instr_valid && i_instr_ready && !i_redirect && !fifo_empty;
  assign push          = wait_resp && !(bypass && i_instr_ready);

  always_comb begin
    o_instr    = '0;
    o_instr_pc = '0;
    if (o_instr_valid) begin
      if (fifo_empty) begin
        o_instr    = i_mem_rdata;
        o_instr_pc = req_pc;
      end else begin
        o_instr    = fifo_data[rd_ptr];
        o_instr_pc = fifo_pc[rd_ptr];
      end
    end
  end

  // NOTE: default assignment first so every path assigns state_nxt and no latch is inferred.
  always_comb begin
    state_nxt = state;
    case (state)
      S_REQ:     if (accept) state_nxt = i_redirect ? S_DISCARD : S_WAIT;
      S_WAIT:    if (i_mem_rvalid) state_nxt = S_REQ;
                 else if (i_redirect) state_nxt = S_DISCARD;
      S_DISCARD: if (i_mem_rvalid) state_nxt = S_REQ;
      default:   state_nxt = S_REQ;
    endcase
  end

  // NOTE: non-blocking assignments for all registered state so every flop samples pre-edge values.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state    <= S_REQ;
      fetch_pc <= RESET_PC;
      req_pc   <= '0;
      rd_ptr   <= '0;
      wr_ptr   <= '0;
      count    <= '0;
    end else begin
      state <= state_nxt;
      if (i_redirect)  fetch_pc <= redirect_target;
      else if (accept) fetch_pc <= fetch_pc + ADDR_WIDTH'(4);
      if (accept) req_pc <= fetch_pc;

      if (i_redirect) begin
        rd_ptr <= '0;
        wr_ptr <= '0;
        count  <= '0;
      end else begin
        if (push) wr_ptr <= wr_ptr + 1'b1;
        if (pop)  rd_ptr <= rd_ptr + 1'b1;
        case ({push, pop})
          2'b10:   count <= count + 1'b1;
          2'b01:   count <= count - 1'b1;
          default: count <= count;
        endcase
      end
    end
  end

  // NOTE: FIFO storage has no reset; count/pointers alone decide which entries are meaningful.
  always_ff @(posedge i_clk) begin
    if (push) begin
      fifo_data[wr_ptr] <= i_mem_rdata;
      fifo_pc[wr_ptr]   <= req_pc;
    end
  end

endmodule

// File: doc/instr_fetch_unit.md
Name: instr_fetch_unit

Overview:
- Requester-side front end of the instruction memory.
- Holds the fetch PC and issues word reads over a request/response handshake. This interface is sized so the plain memory can later be swapped for a cache.
- Buffers returned instructions in a small prefetch FIFO and presents them to decode with a valid/ready handshake.
- Supports PC redirect from branch/jump resolution, flushing stale work.

Parameters:
- DATA_WIDTH, 32, instruction word width.
- ADDR_WIDTH, 32, byte address width of the fetch PC.
- FIFO_DEPTH, 4, prefetch buffer entries; power of two, >= 2.
- RESET_PC, 0, fetch PC loaded on reset; word aligned.

Ports:
- i_clk  input  1  clock, all state on rising edge.
- i_rst  input  1  synchronous, active-high reset.
- o_mem_req  output  1  read request valid.
- o_mem_addr  output  ADDR_WIDTH  byte address of the request; always word aligned.
- i_mem_ready  input  1  memory accepts the request this cycle.
- i_mem_rvalid  input  1  read data valid; responses return in order, at least 1 cycle after acceptance.
- i_mem_rdata  input  DATA_WIDTH  read data.
- o_instr_valid  output  1  instruction available to decode.
- o_instr  output  DATA_WIDTH  instruction word.
- o_instr_pc  output  ADDR_WIDTH  PC of o_instr.
- i_instr_ready  input  1  decode consumes the instruction when valid && ready.
- i_redirect  input  1  single-cycle pulse: flush and restart fetch.
- i_redirect_pc  input  ADDR_WIDTH  new fetch PC; bits [1:0] ignored (forced 0).

Behaviour:
- Reset (i_rst high at a clock edge):
  - fetch_pc = RESET_PC, FIFO empty, state = REQ.
  - o_mem_req = 0, o_instr_valid = 0, o_instr = 0, o_instr_pc = 0 while i_rst is high.
- A transfer occurs only on o_mem_req && i_mem_ready. At most one request is outstanding.
- FSM states:
  - REQ:
    - o_mem_req = 1 when the FIFO has a free entry (count < FIFO_DEPTH); o_mem_addr = fetch_pc.
    - On acceptance: latch req_pc = fetch_pc, fetch_pc += 4 (modulo 2^ADDR_WIDTH), go to WAIT.
    - While not accepted, o_mem_addr is held stable.
  - WAIT:
    - o_mem_req = 0.
    - On i_mem_rvalid: push {rdata, req_pc} into the FIFO, go to REQ. A free slot is guaranteed by the REQ space check.
  - DISCARD:
    - o_mem_req = 0.
    - On i_mem_rvalid: drop the data, go to REQ.
- Throughput: with a 1-cycle memory, one instruction per 2 cycles.
- FIFO:
  - Registered output. o_instr_valid = !empty; o_instr and o_instr_pc come from the head entry.
  - Push and pop in the same cycle are allowed, including when full (pop frees the slot first for the space check on the next cycle only).
  - Count range 0..FIFO_DEPTH.
- Redirect (highest priority, evaluated each cycle):
  - FIFO cleared next cycle; any same-cycle pop or push is ignored.
  - fetch_pc = {i_redirect_pc[ADDR_WIDTH-1:2], 2'b00}.
  - REQ -> REQ with the new address next cycle. An unaccepted request may be withdrawn; a request accepted in the redirect cycle counts as outstanding -> DISCARD.
  - WAIT -> DISCARD, unless i_mem_rvalid arrives in that same cycle: data dropped, -> REQ.
  - DISCARD -> DISCARD, unless rvalid arrives in that cycle, then -> REQ.
  - o_instr_valid = 0 in the cycle after a redirect.
- Reset mid-operation: all state cleared as above. A memory response arriving after reset is not expected; the memory side is reset together.
- Decode stall (i_instr_ready = 0): the FIFO fills, then REQ holds o_mem_req = 0 until space frees.

Optional Feature:
- FETCH_BYPASS_EN defined:
  - When the FIFO is empty, i_mem_rvalid is high in WAIT, and no redirect: o_instr_valid = 1 that same cycle, with o_instr = i_mem_rdata and o_instr_pc = req_pc.
  - If i_instr_ready is also high, the word is consumed and not pushed; otherwise it is pushed.
- FETCH_BYPASS_EN not defined: outputs come only from the FIFO; minimum latency rvalid -> o_instr_valid is 1 cycle.

Test Plan:
- Reset, RESET_PC = 0, memory ready = 1, 1-cycle rdata = addr ^ 32'hA5A5_0000, decode always ready -> requests at 0x0, 0x4, 0x8 on every other cycle; decode sees matching words with o_instr_pc = 0x0, 0x4, 0x8 in order.
- Decode ready held 0 -> exactly 4 requests issued (0x0..0xC), o_mem_req stays 0. Release ready -> 4 pops, then fetch resumes at 0x10.
- Redirect to 0x103 while a request to 0x8 is outstanding -> the 0x8 response is dropped, FIFO is empty next cycle, next request is 0x100, and the first delivered o_instr_pc = 0x100.
- Redirect in the same cycle as a pop with a 3-entry FIFO -> the FIFO is empty afterwards, no instruction from the old stream appears, and fetch restarts at the new PC.
- i_mem_ready low for 5 cycles -> o_mem_addr holds 0x0 stable and fetch_pc does not advance. Assert i_rst mid-stream -> all outputs 0 during reset, fetch restarts at RESET_PC.
- FETCH_BYPASS_EN, FIFO empty, decode ready -> o_instr_valid high in the same cycle as i_mem_rvalid. Without the macro -> valid rises 1 cycle later.
